// File: rtl/seg7_scan_driver.sv
// Scanned multi-digit common-anode seven-segment driver with a tear-free shadow register.
// Define SEG7_LZ_BLANK_EN to blank leading zero digits (digit 0 is never blanked).
module seg7_scan_driver #(
    parameter int DIGITS = 4,
    parameter int DIV    = 50000
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   data,
    input  logic [DIGITS-1:0]     dp,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  pending,
    output logic                  frame
);

    localparam int PCNT_W = $clog2(DIV);
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PCNT_W-1:0] PCNT_MAX = PCNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_MAX  = IDX_W'(DIGITS - 1);

    logic [PCNT_W-1:0]   pcnt_q, pcnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] shadow_data_q, shadow_data_d;
    logic [DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0] disp_data_q, disp_data_d;
    logic [DIGITS-1:0]   disp_dp_q, disp_dp_d;
    logic                pending_q, pending_d;
    logic                frame_q, frame_d;
    logic [7:0]          seg_q, seg_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                tick;
    logic                wrap;
    logic [4*DIGITS-1:0] nib_sh;
    logic [DIGITS-1:0]   dp_sh;
    logic [3:0]          cur_nib;
    logic                cur_dp;
    logic [6:0]          seg_low;

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    always_comb begin
        tick   = (pcnt_q == PCNT_MAX);
        wrap   = tick && (idx_q == IDX_MAX);
        pcnt_d = tick ? '0 : pcnt_q + 1'b1;
        if (wrap)
            idx_d = '0;
        else if (tick)
            idx_d = idx_q + 1'b1;
        else
            idx_d = idx_q;
    end

    // A load landing on the wrap tick bypasses the shadow so it is not held a whole frame.
    always_comb begin
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        disp_data_d   = disp_data_q;
        disp_dp_d     = disp_dp_q;
        pending_d     = pending_q;
        if (load) begin
            shadow_data_d = data;
            shadow_dp_d   = dp;
        end
        if (wrap) begin
            pending_d = 1'b0;
            if (load) begin
                disp_data_d = data;
                disp_dp_d   = dp;
            end else if (pending_q) begin
                disp_data_d = shadow_data_q;
                disp_dp_d   = shadow_dp_q;
            end
        end else if (load) begin
            pending_d = 1'b1;
        end
    end

    // nib_sh holds the current nibble and everything above it, which also serves the blanking test.
    always_comb begin
        nib_sh  = disp_data_q >> {idx_q, 2'b00};
        dp_sh   = disp_dp_q >> idx_q;
        cur_nib = nib_sh[3:0];
        cur_dp  = dp_sh[0];
`ifdef SEG7_LZ_BLANK_EN
        if ((idx_q != '0) && (nib_sh == '0))
            seg_low = 7'h7F;
        else
            seg_low = hex_decode(cur_nib);
`else
        seg_low = hex_decode(cur_nib);
`endif
        seg_d   = {~cur_dp, seg_low};
        an_d    = ~(DIGITS'(1) << idx_q);
        frame_d = wrap;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            pcnt_q        <= '0;
            idx_q         <= '0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            disp_data_q   <= '0;
            disp_dp_q     <= '0;
            pending_q     <= 1'b0;
            frame_q       <= 1'b0;
            seg_q         <= 8'hFF;
            an_q          <= '1;
        end else begin
            pcnt_q        <= pcnt_d;
            idx_q         <= idx_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            disp_data_q   <= disp_data_d;
            disp_dp_q     <= disp_dp_d;
            pending_q     <= pending_d;
            frame_q       <= frame_d;
            seg_q         <= seg_d;
            an_q          <= an_d;
        end
    end

    assign seg     = seg_q;
    assign an      = an_q;
    assign pending = pending_q;
    assign frame   = frame_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: a cycle-count reference model predicts every output cycle.
// Honours SEG7_LZ_BLANK_EN when the bundle is built with it.
module tb_seg7_scan_driver;

    localparam int DIGITS = 4;
    localparam int DIV    = 4;
    localparam int FRAME  = DIGITS * DIV;
    localparam int W      = 8 + DIGITS + 2;

    logic                clk;
    logic                clr;
    logic                load;
    logic [4*DIGITS-1:0] data;
    logic [DIGITS-1:0]   dp;
    logic [7:0]          seg;
    logic [DIGITS-1:0]   an;
    logic                pending;
    logic                frame;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] exp_q[$];

    logic [6:0] hex_tbl [0:15] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                   7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // reference state: clock edges since reset release plus what is shown / waiting
    int                  k;
    logic [4*DIGITS-1:0] m_data, m_sh;
    logic [DIGITS-1:0]   m_dp, m_sh_dp;
    logic                m_pend;

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk     (clk),
        .clr     (clr),
        .load    (load),
        .data    (data),
        .dp      (dp),
        .seg     (seg),
        .an      (an),
        .pending (pending),
        .frame   (frame)
    );

    // clock / reset block
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s at t=%0t edge=%0d: actual=%h required=%h", name, $time, k, act, req);
        end
    endtask

    // reference model: digit slot and wrap derived from the edge count alone
    always @(posedge clk) begin
        int          d;
        logic [4*DIGITS-1:0] up;
        logic [6:0]  lo;
        logic        dpb;
        logic        wrap;
        logic [DIGITS-1:0] an_e;
        if (!clr) begin
            k       = 0;
            m_data  = '0;
            m_dp    = '0;
            m_sh    = '0;
            m_sh_dp = '0;
            m_pend  = 1'b0;
            exp_q.push_back({8'hFF, {DIGITS{1'b1}}, 1'b0, 1'b0});
        end else begin
            k++;
            d    = ((k - 1) / DIV) % DIGITS;
            up   = m_data >> (4 * d);
            lo   = hex_tbl[up[3:0]];
`ifdef SEG7_LZ_BLANK_EN
            if (d >= 1 && up == '0) lo = 7'h7F;
`endif
            dpb  = m_dp[d];
            an_e = ~(DIGITS'(1) << d);
            wrap = (k % FRAME) == 0;
            if (wrap) begin
                if (load) begin
                    m_data = data;
                    m_dp   = dp;
                end else if (m_pend) begin
                    m_data = m_sh;
                    m_dp   = m_sh_dp;
                end
                m_pend = 1'b0;
            end else if (load) begin
                m_sh    = data;
                m_sh_dp = dp;
                m_pend  = 1'b1;
            end
            exp_q.push_back({~dpb, lo, an_e, wrap, m_pend});
        end
    end

    // monitor: one expected entry per clock edge
    always @(posedge clk) begin
        logic [W-1:0] e;
        #1;
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL queue_empty at t=%0t: actual=0 entries required=1", $time);
        end else begin
            e = exp_q.pop_front();
            chk("seg", seg, e[W-1 -: 8]);
            chk("an", 8'(an), 8'(e[DIGITS+1:2]));
            chk("frame", 8'(frame), 8'(e[1]));
            chk("pending", 8'(pending), 8'(e[0]));
        end
    end

    // driver tasks: all called and returning at a falling edge
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_load(input logic [4*DIGITS-1:0] d, input logic [DIGITS-1:0] p);
        load = 1'b1;
        data = d;
        dp   = p;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic clr_pulse();
        clr = 1'b0;
        #1;
        chk("clr_seg", seg, 8'hFF);
        chk("clr_an", 8'(an), 8'(4'hF));
        chk("clr_pending", 8'(pending), 8'h00);
        chk("clr_frame", 8'(frame), 8'h00);
        @(negedge clk);
        clr = 1'b1;
    endtask

    task automatic wait_wrap_next();
        bit found = 1'b0;
        for (int i = 0; i <= FRAME; i++) begin
            if (((k + 1) % FRAME) == 0) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL wrap_wait: actual=not reached required=wrap within %0d cycles", FRAME + 1);
        end
    endtask

    initial begin
        clr  = 1'b0;
        load = 1'b0;
        data = '0;
        dp   = '0;
        idle(3);
        clr = 1'b1;
        idle(5);
        do_load(16'h1234, 4'b0010);
        idle(40);
        do_load(16'hAAAA, 4'b0000);
        do_load(16'hBEEF, 4'b0000);
        idle(40);
        wait_wrap_next();
        do_load(16'hC0DE, 4'b0000);
        idle(20);
        do_load(16'h0070, 4'b0000);
        idle(40);
        do_load(16'h9876, 4'b1001);
        idle(5);
        clr_pulse();
        idle(30);
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 299) == 0)
                clr_pulse();
            else if ($urandom_range(0, 5) == 0) begin
                if ($urandom_range(0, 2) == 0)
                    do_load(16'($urandom_range(0, 255)), 4'($urandom));
                else
                    do_load(16'($urandom), 4'($urandom));
            end else
                idle(1);
        end
        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
